// File: rtl/muxn_rr.sv
// N-to-1 registered multiplexer with direct-select and round-robin grant modes.
// Optional feature: define MUXN_RR_COUNT_EN to add the 16-bit out_count transfer counter.
module muxn_rr #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef MUXN_RR_COUNT_EN
    output logic [15:0]     out_count,
`endif
    output logic [SW-1:0]   out_chan
);

    localparam logic [SW:0]   N_EXT = (SW+1)'(N);
    localparam logic [SW-1:0] LAST  = SW'(N-1);

    logic [W-1:0]  out_data_q,  out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_chan_q,  out_chan_d;
    logic [SW-1:0] ptr_q,       ptr_d;

    logic [SW-1:0] dir_g_s;
    logic [SW-1:0] rr_g_s;
    logic [SW-1:0] cand_s;
    logic          rr_hit_s;
    logic [SW-1:0] g_s;
    logic          grant_valid_s;
    logic          can_accept_s;
    logic          xfer_s;
    logic [W-1:0]  sel_data_s;

    // Direct-mode grant: out-of-range selects clamp to the last channel.
    always_comb begin
        dir_g_s = LAST;
        if ({1'b0, s} < N_EXT) begin
            dir_g_s = s;
        end else begin
            dir_g_s = LAST;
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        rr_hit_s = 1'b0;
        rr_g_s   = ptr_q;
        cand_s   = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (cand_s == LAST) begin
                cand_s = {SW{1'b0}};
            end else begin
                cand_s = cand_s + 1'b1;
            end
            if (!rr_hit_s && in_valid[cand_s]) begin
                rr_hit_s = 1'b1;
                rr_g_s   = cand_s;
            end else begin
                rr_hit_s = rr_hit_s;
            end
        end
    end

    // Grant selection, handshake and granted-data mux.
    always_comb begin
        can_accept_s  = !out_valid_q || out_ready;
        g_s           = mode ? rr_g_s : dir_g_s;
        grant_valid_s = mode ? rr_hit_s : in_valid[dir_g_s];
        xfer_s        = !rst && can_accept_s && grant_valid_s;
        in_ready      = {N{1'b0}};
        if (xfer_s) begin
            in_ready = {{(N-1){1'b0}}, 1'b1} << g_s;
        end else begin
            in_ready = {N{1'b0}};
        end
        sel_data_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (g_s == SW'(i)) begin
                sel_data_s = in_data[i*W +: W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Output slot next state: fill on transfer, drain on accept, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_chan_d  = g_s;
            ptr_d       = g_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; ptr resets to the last channel so the first search starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            out_chan_q  <= {SW{1'b0}};
            ptr_q       <= LAST;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

`ifdef MUXN_RR_COUNT_EN
    logic [15:0] out_count_q, out_count_d;

    // Count accepted output words, wrapping naturally at 16 bits.
    always_comb begin
        out_count_d = out_count_q;
        if (out_valid_q && out_ready) begin
            out_count_d = out_count_q + 16'd1;
        end else begin
            out_count_d = out_count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count_q <= 16'd0;
        end else begin
            out_count_q <= out_count_d;
        end
    end

    assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_muxn_rr.sv
// Self-checking bench for muxn_rr: directed scenarios plus randomized traffic against a
// transaction-level model; a second N=3 instance covers out-of-range direct select.
module tb_muxn_rr;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  s;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_chan;
`ifdef MUXN_RR_COUNT_EN
    logic [15:0]    out_count;
`endif

    logic           rst3;
    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_ready3;
    logic           mode3;
    logic [1:0]     s3;
    logic [W-1:0]   out_data3;
    logic           out_valid3;
    logic           out_ready3;
    logic [1:0]     out_chan3;
`ifdef MUXN_RR_COUNT_EN
    logic [15:0]    out_count3;
`endif

    muxn_rr #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .s(s), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUXN_RR_COUNT_EN
        .out_count(out_count),
`endif
        .out_chan(out_chan)
    );

    muxn_rr #(.N(3), .W(W)) dut3 (
        .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .s(s3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
`ifdef MUXN_RR_COUNT_EN
        .out_count(out_count3),
`endif
        .out_chan(out_chan3)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level view of the output slot and the round-robin position.
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_chan;
    int         m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic md, input int sel, input logic [N-1:0] v,
                                       output bit hit);
        int g;
        hit = 1'b0;
        g   = 0;
        if (!md) begin
            g   = (sel < N) ? sel : N - 1;
            hit = v[g];
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!hit && v[(m_ptr + k) % N]) begin
                    hit = 1'b1;
                    g   = (m_ptr + k) % N;
                end
            end
        end
        return g;
    endfunction

    // Called just after a falling edge with inputs applied; returns after the next falling edge.
    task automatic step();
        bit           hit;
        bit           xfer;
        int           g;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] word;
        g       = model_grant(mode, int'(s), in_valid, hit);
        xfer    = !rst && hit && (!m_valid || out_ready);
        exp_rdy = xfer ? (4'b0001 << g) : 4'b0000;
        word    = in_data[g*W +: W];
        #1;
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = 8'h00; m_chan = 0; m_ptr = N - 1;
        end else if (xfer) begin
            m_valid = 1'b1; m_data = word; m_chan = g; m_ptr = g;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_data", {24'd0, out_data}, {24'd0, m_data});
        chk("out_chan", {30'd0, out_chan}, m_chan);
        @(negedge clk);
    endtask

    initial begin
        m_valid = 1'b0; m_data = 8'h00; m_chan = 0; m_ptr = N - 1;
        rst = 1'b1; in_data = '0; in_valid = 4'b0000; mode = 1'b0; s = 2'd0; out_ready = 1'b0;
        rst3 = 1'b1; in_data3 = '0; in_valid3 = 3'b000; mode3 = 1'b0; s3 = 2'd0; out_ready3 = 1'b1;
        @(negedge clk);

        // Reset state
        step();
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_chan", {30'd0, out_chan}, 32'd0);

        // Out-of-range direct select on a 3-channel instance
        rst3 = 1'b0; s3 = 2'd3; in_valid3 = 3'b100; in_data3 = {8'h3C, 8'h22, 8'h11};
        #1;
        chk("oor_ready", {29'd0, in_ready3}, 32'h4);
        @(posedge clk); #1;
        chk("oor_valid", {31'd0, out_valid3}, 32'd1);
        chk("oor_data", {24'd0, out_data3}, 32'h3C);
        chk("oor_chan", {30'd0, out_chan3}, 32'd2);
        @(negedge clk);
        in_valid3 = 3'b000;

        // Direct select of channel 2
        rst = 1'b0; mode = 1'b0; s = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        step();
        chk("direct_data", {24'd0, out_data}, 32'hA5);
        chk("direct_chan", {30'd0, out_chan}, 32'd2);
        in_valid = 4'b1011;
        step();
        chk("direct_ignore", {31'd0, out_valid}, 32'd0);
        chk("direct_hold", {24'd0, out_data}, 32'hA5);

        // Round-robin over four always-valid channels
        rst = 1'b1; step(); rst = 1'b0;
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_seq", {30'd0, out_chan}, i % 4);
        end

        // Backpressure: word held stable, then no bubble when released
        rst = 1'b1; step(); rst = 1'b0;
        mode = 1'b0; s = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
        in_data = {8'hD4, 8'hC3, 8'h5A, 8'hA1};
        step();
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_data", {24'd0, out_data}, 32'h5A);
            chk("bp_rdy", {28'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_chan", {30'd0, out_chan}, 32'd2);
        chk("bp_next_data", {24'd0, out_data}, 32'hC3);

        // Reset mid-stream restarts round-robin at channel 0
        out_ready = 1'b0; step();
        rst = 1'b1; step();
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0; out_ready = 1'b1; step();
        chk("rst_first_rr", {30'd0, out_chan}, 32'd0);

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            rst       = ($urandom_range(0, 59) == 0);
            mode      = $urandom_range(0, 1);
            s         = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

`ifdef MUXN_RR_COUNT_EN
        // 65537 accepted words wrap the counter to 1
        rst = 1'b1; mode = 1'b0; s = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        @(negedge clk);
        chk("count_reset", {16'd0, out_count}, 32'd0);
        rst = 1'b0;
        repeat (65538) @(posedge clk);
        #1;
        chk("count_wrap", {16'd0, out_count}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muxn_rr.md
MUXN_RR -- requirements
Module: muxn_rr

Interface
REQ-001 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-002 Parameter W, default 8, data width per channel in bits.
REQ-003 Derived localparam SW = clog2(N), select/channel-index width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-008 in_valid  input  N  per-channel data valid.
REQ-009 in_ready  output  N  per-channel accept strobe; at most one bit high per cycle.
REQ-010 mode  input  1  0 = direct select by s, 1 = round-robin.
REQ-011 s  input  SW  direct-mode channel select.
REQ-012 out_data  output  W  registered selected data.
REQ-013 out_valid  output  1  out_data holds an untaken word.
REQ-014 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-015 out_chan  output  SW  source channel index of out_data.

Function
REQ-016 Output stage SHALL be a single register slot; can_accept = !out_valid || out_ready.
REQ-017 A transfer in SHALL occur when can_accept is high and the granted channel g has in_valid[g] high; in_ready[g] SHALL then be high combinationally, with all other in_ready bits low.
REQ-018 On a transfer in, out_data, out_chan and out_valid=1 SHALL update at the next clk edge; latency is 1 cycle.
REQ-019 When out_valid && out_ready and no new transfer occurs, out_valid SHALL clear next cycle; out_data and out_chan SHALL hold their values.
REQ-020 Simultaneous drain and fill SHALL sustain one word per cycle with no bubble.
REQ-021 While out_valid && !out_ready, out_data and out_chan SHALL remain stable and all in_ready bits SHALL be low.
REQ-022 Direct mode: g = s when s < N; when s >= N, g = N-1.
REQ-023 Direct mode: if in_valid[g] is low, no transfer occurs; other valid channels SHALL be ignored.
REQ-024 Round-robin mode: g is the first channel with in_valid high, searching ptr+1, ptr+2, ... modulo N, wrapping from N-1 to 0.
REQ-025 ptr SHALL update to g only on a transfer in, in either mode; with no valid channel, ptr holds.
REQ-026 A mode or s change SHALL affect only the next grant decision and never the held output word.

Reset
REQ-027 While rst is high at a clk edge: out_valid=0, out_data=0, out_chan=0, ptr=N-1, so the first round-robin grant searches from channel 0.
REQ-028 Reset mid-transfer SHALL discard the held word; in_ready SHALL be low during the reset cycle.

Configuration
REQ-029 With MUXN_RR_COUNT_EN defined: add output port out_count (16 bits), incremented on each out_valid && out_ready, wrapping 0xFFFF->0x0000, and reset to 0.
REQ-030 With MUXN_RR_COUNT_EN undefined: out_count port and counter logic SHALL be absent; all other behaviour is identical.

Verification (N=4, W=8)
REQ-031 Direct: mode=0, s=2, in_valid=4'b0100, in_data ch2=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_chan=2.
REQ-032 Direct out-of-range: N=3, s=3, ch2=0x3C valid -> out_data=0x3C, out_chan=2.
REQ-033 Round-robin: all four channels held valid, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 Backpressure: out_ready=0 for 3 cycles with a word held -> out_data stable, in_ready=0; out_ready=1 -> the next word follows with no bubble.
REQ-035 Reset mid-stream: assert rst while out_valid=1 -> out_valid=0 next cycle; first round-robin grant afterwards is channel 0.
REQ-036 MUXN_RR_COUNT_EN: 65537 transfers -> out_count=1.
